// File: rtl/adder_result_accum.sv
// Capture stage behind the carry-select adder: sums COUNT {cout,sum} samples per batch
// and hands the batch total plus a sticky wrap flag downstream over valid/ready.
module adder_result_accum #(
   parameter int WIDTH     = 46,
   parameter int ACC_WIDTH = 54,
   parameter int COUNT     = 16,
   localparam int CNT_W    = $clog2(COUNT + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clear,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WIDTH-1:0]     i_sum,
   input  logic                 i_cout,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [ACC_WIDTH-1:0] o_acc,
   output logic                 o_ovf,
   output logic [CNT_W-1:0]     o_count
);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               state;
   state_t               state_next;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] res_acc;
   logic [CNT_W-1:0]     count;
   logic                 ovf;
   logic                 res_ovf;
   logic                 accept;
   logic                 last;
   logic [ACC_WIDTH:0]   acc_sum;

   // Returns {carry, sum}; the top bit is the wrap out of the accumulator.
   function automatic logic [ACC_WIDTH:0] add_sample(input logic [ACC_WIDTH-1:0] a,
                                                     input logic             c,
                                                     input logic [WIDTH-1:0] s);
      return {1'b0, a} + (ACC_WIDTH+1)'({c, s});
   endfunction

   assign accept  = (state == ACCUM) && i_valid;
   assign last    = (count == CNT_W'(COUNT - 1));
   assign acc_sum = add_sample(acc, i_cout, i_sum);

   always_comb begin
      state_next = state;
      if (i_clear) begin
         state_next = ACCUM;
      end else begin
         case (state)
            ACCUM:   if (accept && last) state_next = HOLD;
            HOLD:    if (i_ready) state_next = ACCUM;
            default: state_next = ACCUM;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ACCUM;
      else          state <= state_next;
   end

   // Running batch state and the registered result presented while in HOLD.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc     <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         res_acc <= '0;
         res_ovf <= 1'b0;
      end else if (i_clear) begin
         acc     <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         res_ovf <= 1'b0;
      end else if (accept) begin
         if (last) begin
            res_acc <= acc_sum[ACC_WIDTH-1:0];
            res_ovf <= ovf | acc_sum[ACC_WIDTH];
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
         end else begin
            acc   <= acc_sum[ACC_WIDTH-1:0];
            count <= count + CNT_W'(1);
            ovf   <= ovf | acc_sum[ACC_WIDTH];
         end
      end else if ((state == HOLD) && i_ready) begin
         res_ovf <= 1'b0;
      end
   end

   assign o_ready = (state == ACCUM);
   assign o_valid = (state == HOLD);
   assign o_acc   = res_acc;
   assign o_ovf   = res_ovf;
   assign o_count = count;

endmodule

// File: tb/tb_adder_result_accum.sv
// Bench for adder_result_accum: three configurations (COUNT=4, a 48-bit COUNT=3 wrap case,
// COUNT=16) driven one at a time, with batch totals scored against a reference model.
module tb_adder_result_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        clear;
   logic        cout;
   logic [45:0] sum;
   logic        vld[3];
   logic        rdy_in[3];
   logic        rdy_o[3];
   logic        vld_o[3];
   logic        ovf_o[3];
   logic [63:0] acc_o[3];
   logic [7:0]  cnt_o[3];

   logic [53:0] acc_a;
   logic [47:0] acc_b;
   logic [53:0] acc_c;
   logic [2:0]  cnt_a;
   logic [1:0]  cnt_b;
   logic [4:0]  cnt_c;

   adder_result_accum #(.WIDTH(46), .ACC_WIDTH(54), .COUNT(4)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(vld[0]), .o_ready(rdy_o[0]),
      .i_sum(sum), .i_cout(cout), .o_valid(vld_o[0]), .i_ready(rdy_in[0]),
      .o_acc(acc_a), .o_ovf(ovf_o[0]), .o_count(cnt_a));

   adder_result_accum #(.WIDTH(46), .ACC_WIDTH(48), .COUNT(3)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(vld[1]), .o_ready(rdy_o[1]),
      .i_sum(sum), .i_cout(cout), .o_valid(vld_o[1]), .i_ready(rdy_in[1]),
      .o_acc(acc_b), .o_ovf(ovf_o[1]), .o_count(cnt_b));

   adder_result_accum #(.WIDTH(46), .ACC_WIDTH(54), .COUNT(16)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(vld[2]), .o_ready(rdy_o[2]),
      .i_sum(sum), .i_cout(cout), .o_valid(vld_o[2]), .i_ready(rdy_in[2]),
      .o_acc(acc_c), .o_ovf(ovf_o[2]), .o_count(cnt_c));

   assign acc_o[0] = 64'(acc_a);
   assign acc_o[1] = 64'(acc_b);
   assign acc_o[2] = 64'(acc_c);
   assign cnt_o[0] = 8'(cnt_a);
   assign cnt_o[1] = 8'(cnt_b);
   assign cnt_o[2] = 8'(cnt_c);

   int tests  = 0;
   int errors = 0;

   int          w_m[3] = '{54, 48, 54};
   int          c_m[3] = '{4, 3, 16};
   logic [63:0] acc_m[3];
   bit          ovf_m[3];
   int          cnt_m[3];
   logic [66:0] exp_q[$];
   bit          vprev[3];

   localparam logic [45:0] ONES = {46{1'b1}};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         acc_m[d] = '0;
         ovf_m[d] = 1'b0;
         cnt_m[d] = 0;
      end
   endtask

   task automatic model_accept(input int d, input logic [46:0] v);
      logic [63:0] full;
      logic        carry;
      full  = acc_m[d] + 64'(v);
      carry = (full >> w_m[d]) != 64'd0;
      full  = full & ((64'd1 << w_m[d]) - 64'd1);
      cnt_m[d]++;
      if (cnt_m[d] == c_m[d]) begin
         exp_q.push_back({2'(d), ovf_m[d] | carry, full});
         acc_m[d] = '0;
         ovf_m[d] = 1'b0;
         cnt_m[d] = 0;
      end else begin
         acc_m[d] = full;
         ovf_m[d] = ovf_m[d] | carry;
      end
   endtask

   // Called just after a falling edge; returns just after the falling edge following the accept.
   task automatic send(input int d, input logic c, input logic [45:0] s);
      int n = 0;
      cout   = c;
      sum    = s;
      vld[d] = 1'b1;
      while (!rdy_o[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_val("send_ready", 64'(rdy_o[d]), 64'd1);
      else         model_accept(d, {c, s});
      @(negedge clk);
   endtask

   // Score each batch result on the cycle its valid rises.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (vld_o[d] && !vprev[d]) begin
            if (exp_q.size() == 0) begin
               check_val("sb_expect", 64'(exp_q.size()), 64'd1);
            end else begin
               logic [66:0] e;
               e = exp_q.pop_front();
               check_val("sb_dut", 64'(d), 64'(e[66:65]));
               check_val("sb_acc", acc_o[d], e[63:0]);
               check_val("sb_ovf", 64'(ovf_o[d]), 64'(e[64]));
            end
         end
         vprev[d] = vld_o[d];
      end
   end

   initial begin
      int gap;
      rst_n = 1'b0;
      clear = 1'b0;
      cout  = 1'b0;
      sum   = '0;
      for (int d = 0; d < 3; d++) begin
         vld[d]    = 1'b0;
         rdy_in[d] = 1'b1;
      end
      model_clear();
      repeat (3) @(negedge clk);
      check_val("rst_ready", 64'(rdy_o[0]), 64'd1);
      check_val("rst_valid", 64'(vld_o[0]), 64'd0);
      check_val("rst_acc", acc_o[0], 64'd0);
      check_val("rst_ovf", 64'(ovf_o[0]), 64'd0);
      check_val("rst_count", 64'(cnt_o[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full-scale batch on COUNT=4
      for (int i = 0; i < 4; i++) send(0, 1'b1, ONES);
      vld[0] = 1'b0;
      check_val("fs_latency", 64'(vld_o[0]), 64'd1);
      check_val("fs_ready", 64'(rdy_o[0]), 64'd0);
      check_val("fs_acc", acc_o[0], (64'd1 << 49) - 64'd4);
      check_val("fs_ovf", 64'(ovf_o[0]), 64'd0);
      @(negedge clk);

      // Asynchronous reset mid-batch
      send(0, 1'b0, 46'd10);
      send(0, 1'b0, 46'd20);
      send(0, 1'b0, 46'd30);
      vld[0] = 1'b0;
      check_val("mid_count", 64'(cnt_o[0]), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_acc", acc_o[0], 64'd0);
      check_val("arst_count", 64'(cnt_o[0]), 64'd0);
      check_val("arst_ready", 64'(rdy_o[0]), 64'd1);
      check_val("arst_valid", 64'(vld_o[0]), 64'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 4; i++) send(0, 1'b0, 46'(i));
      vld[0] = 1'b0;
      check_val("post_rst_acc", acc_o[0], 64'd10);
      @(negedge clk);

      // Backpressure with upstream holding a sample
      rdy_in[0] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 1'b0, 46'd3);
      sum = 46'd9;
      for (int i = 0; i < 5; i++) begin
         check_val("bp_ready", 64'(rdy_o[0]), 64'd0);
         check_val("bp_valid", 64'(vld_o[0]), 64'd1);
         check_val("bp_acc", acc_o[0], 64'd12);
         check_val("bp_count", 64'(cnt_o[0]), 64'd0);
         @(negedge clk);
      end
      rdy_in[0] = 1'b1;
      @(negedge clk);
      check_val("bp_release", 64'(rdy_o[0]), 64'd1);
      check_val("bp_ovf_drop", 64'(ovf_o[0]), 64'd0);
      send(0, 1'b0, 46'd9);
      for (int i = 0; i < 3; i++) send(0, 1'b0, 46'd1);
      vld[0] = 1'b0;
      check_val("bp_next_acc", acc_o[0], 64'd12);
      @(negedge clk);

      // Clear mid-batch discards the concurrent sample
      send(0, 1'b0, 46'd5);
      send(0, 1'b0, 46'd7);
      sum   = 46'd100;
      clear = 1'b1;
      @(negedge clk);
      clear  = 1'b0;
      vld[0] = 1'b0;
      model_clear();
      check_val("clr_count", 64'(cnt_o[0]), 64'd0);
      check_val("clr_acc_kept", acc_o[0], 64'd12);
      for (int i = 0; i < 4; i++) send(0, 1'b0, 46'd1);
      vld[0] = 1'b0;
      check_val("clr_next_acc", acc_o[0], 64'd4);
      @(negedge clk);

      // Clear while a result is held
      rdy_in[0] = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 1'b0, 46'd2);
      vld[0] = 1'b0;
      check_val("hold_valid", 64'(vld_o[0]), 64'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_clear();
      check_val("hold_clr_valid", 64'(vld_o[0]), 64'd0);
      check_val("hold_clr_ready", 64'(rdy_o[0]), 64'd1);
      check_val("hold_clr_acc", acc_o[0], 64'd8);
      rdy_in[0] = 1'b1;
      @(negedge clk);

      // Accumulator wrap on the 48-bit COUNT=3 instance
      for (int i = 0; i < 3; i++) send(1, 1'b1, ONES);
      vld[1] = 1'b0;
      check_val("wrap_acc", acc_o[1], (64'd1 << 47) - 64'd3);
      check_val("wrap_ovf", 64'(ovf_o[1]), 64'd1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) send(1, 1'b0, 46'd0);
      vld[1] = 1'b0;
      check_val("zero_acc", acc_o[1], 64'd0);
      check_val("zero_ovf", 64'(ovf_o[1]), 64'd0);
      @(negedge clk);

      // Stalling upstream on the COUNT=16 instance
      for (int i = 1; i <= 16; i++) begin
         gap = $urandom_range(0, 2);
         vld[2] = 1'b0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_val("stall_count_idle", 64'(cnt_o[2]), 64'(i - 1));
         end
         send(2, 1'b0, 46'(i));
         check_val("stall_count", 64'(cnt_o[2]), 64'(i % 16));
      end
      vld[2] = 1'b0;
      check_val("stall_acc", acc_o[2], 64'd136);

      repeat (3) @(negedge clk);
      check_val("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
